// File: rtl/discharge_pkg.sv
// Shared definitions for the EDM discharge channel: state codes (also decoded by
// the breakdown detector), waveform control bit positions and a time-floor helper.
package discharge_pkg;

    typedef enum logic [7:0] {
        S_IDLE              = 8'b0100_0000,
        S_WAIT_BREAKDOWN    = 8'b0000_0001,
        S_BUCK_INTERLEAVE   = 8'b0000_0010,
        S_RES_DISCHARGE     = 8'b0000_0100,
        S_DEION             = 8'b1000_0000,
        S_DEION_SINGLE_BUCK = 8'b0000_0000
    } state_t;

    localparam int BUCK_OR_RES_BIT        = 15;
    localparam int CONTINUE_OR_SINGLE_BIT = 14;

    function automatic logic [15:0] floor_time(input logic [15:0] t, input logic [15:0] min_t);
        return (t < min_t) ? min_t : t;
    endfunction

endpackage

// File: rtl/discharge_pulse_sequencer_buck_phase_gen.sv
// Two-phase non-overlapping buck switch generator; starts on phase 01 when enabled
// and swaps phase every half_period cycles, returning to 00 when disabled.
module buck_phase_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] half_period,
    output logic [1:0]  phase
);

    logic [15:0] cnt;

    // cnt holds how many cycles the current phase has been driven, including this one
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= 2'b00;
            cnt   <= 16'd0;
        end else if (!enable) begin
            phase <= 2'b00;
            cnt   <= 16'd0;
        end else if (phase == 2'b00) begin
            phase <= 2'b01;
            cnt   <= 16'd1;
        end else if (cnt >= half_period) begin
            phase <= {phase[0], phase[1]};
            cnt   <= 16'd1;
        end else begin
            cnt   <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/discharge_pulse_sequencer.sv
// Pulse state machine for one EDM discharge channel.
// Optional open-gap abort is built when DISCHARGE_OPEN_TIMEOUT_EN is defined.
//
// state               | meaning
// S_IDLE              | switches off, waiting for enable / single start
// S_WAIT_BREAKDOWN    | gap supply on, waiting for the gap to break down
// S_BUCK_INTERLEAVE   | discharge through interleaved buck phases
// S_RES_DISCHARGE     | discharge through the resistor path
// S_DEION             | de-ionisation gap in a continuous train
// S_DEION_SINGLE_BUCK | de-ionisation after a single pulse, then idle
module discharge_pulse_sequencer
    import discharge_pkg::*;
#(
    parameter logic [15:0] BUCK_HALF_PERIOD = 16'd50,
    parameter logic [31:0] WAIT_TIMEOUT     = 32'd100000,
    parameter logic [15:0] MIN_ON_TIME      = 16'd1,
    parameter logic [15:0] MIN_OFF_TIME     = 16'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        emergency_stop,
    input  logic        single_start,
    input  logic [15:0] waveform,
    input  logic [15:0] pulse_on_time,
    input  logic [15:0] pulse_off_time,
    input  logic        is_breakdown,
    output logic [7:0]  current_state,
    output logic [31:0] timer_wait_breakdown,
    output logic        mosfet_main,
    output logic        mosfet_res,
    output logic [1:0]  mosfet_buck,
    output logic        single_done,
    output logic        open_abort,
    output logic [31:0] pulse_count
);

    state_t      state, state_nxt;
    logic        mode_buck, mode_single;
    logic [15:0] on_time, off_time;
    logic [15:0] cnt;
    logic        relatch, cnt_clr, disch_done, done_pulse;
    logic        on_last, off_last;

    assign on_last  = ({1'b0, cnt} + 17'd1) >= {1'b0, on_time};
    assign off_last = ({1'b0, cnt} + 17'd1) >= {1'b0, off_time};

`ifdef DISCHARGE_OPEN_TIMEOUT_EN
    logic abort_pulse, abort_q;
    logic timeout_hit;
    assign timeout_hit = (timer_wait_breakdown == WAIT_TIMEOUT - 32'd1);
`endif

    always_comb begin
        state_nxt  = state;
        relatch    = 1'b0;
        cnt_clr    = 1'b0;
        disch_done = 1'b0;
        done_pulse = 1'b0;
`ifdef DISCHARGE_OPEN_TIMEOUT_EN
        abort_pulse = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (enable && (!waveform[CONTINUE_OR_SINGLE_BIT] || single_start)) begin
                    state_nxt = S_WAIT_BREAKDOWN;
                    relatch   = 1'b1;
                end
            end
            S_WAIT_BREAKDOWN: begin
                if (is_breakdown) begin
                    state_nxt = mode_buck ? S_BUCK_INTERLEAVE : S_RES_DISCHARGE;
                    cnt_clr   = 1'b1;
                end
`ifdef DISCHARGE_OPEN_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_nxt   = mode_single ? S_DEION_SINGLE_BUCK : S_DEION;
                    cnt_clr     = 1'b1;
                    abort_pulse = 1'b1;
                end
`endif
            end
            S_BUCK_INTERLEAVE, S_RES_DISCHARGE: begin
                if (on_last) begin
                    state_nxt  = mode_single ? S_DEION_SINGLE_BUCK : S_DEION;
                    cnt_clr    = 1'b1;
                    disch_done = 1'b1;
                end
            end
            S_DEION: begin
                if (off_last) begin
                    cnt_clr = 1'b1;
                    if (enable) begin
                        state_nxt = S_WAIT_BREAKDOWN;
                        relatch   = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DEION_SINGLE_BUCK: begin
                if (off_last) begin
                    state_nxt  = S_IDLE;
                    cnt_clr    = 1'b1;
                    done_pulse = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Emergency stop overrides everything, including a discharge finishing this cycle
        if (emergency_stop) begin
            state_nxt  = S_IDLE;
            relatch    = 1'b0;
            cnt_clr    = 1'b1;
            disch_done = 1'b0;
            done_pulse = 1'b0;
`ifdef DISCHARGE_OPEN_TIMEOUT_EN
            abort_pulse = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= S_IDLE;
            mode_buck            <= 1'b0;
            mode_single          <= 1'b0;
            on_time              <= 16'd0;
            off_time             <= 16'd0;
            cnt                  <= 16'd0;
            timer_wait_breakdown <= 32'd0;
            pulse_count          <= 32'd0;
            mosfet_main          <= 1'b0;
            mosfet_res           <= 1'b0;
            single_done          <= 1'b0;
        end else begin
            state <= state_nxt;
            if (relatch) begin
                mode_buck            <= waveform[BUCK_OR_RES_BIT];
                mode_single          <= waveform[CONTINUE_OR_SINGLE_BIT];
                on_time              <= floor_time(pulse_on_time, MIN_ON_TIME);
                off_time             <= floor_time(pulse_off_time, MIN_OFF_TIME);
                timer_wait_breakdown <= 32'd0;
            end else if (state == S_WAIT_BREAKDOWN && timer_wait_breakdown != 32'hFFFF_FFFF) begin
                timer_wait_breakdown <= timer_wait_breakdown + 32'd1;
            end
            if (cnt_clr) begin
                cnt <= 16'd0;
            end else if (state != S_IDLE && state != S_WAIT_BREAKDOWN) begin
                cnt <= cnt + 16'd1;
            end
            if (disch_done && pulse_count != 32'hFFFF_FFFF) begin
                pulse_count <= pulse_count + 32'd1;
            end
            mosfet_main <= (state_nxt == S_WAIT_BREAKDOWN) || (state_nxt == S_BUCK_INTERLEAVE)
                        || (state_nxt == S_RES_DISCHARGE);
            mosfet_res  <= (state_nxt == S_RES_DISCHARGE);
            single_done <= done_pulse;
        end
    end

`ifdef DISCHARGE_OPEN_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= abort_pulse;
        end
    end
    assign open_abort = abort_q;
`else
    assign open_abort = 1'b0;
`endif

    assign current_state = state;

    buck_phase_gen u_buck_phase_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (state_nxt == S_BUCK_INTERLEAVE),
        .half_period (BUCK_HALF_PERIOD),
        .phase       (mosfet_buck)
    );

endmodule
